life_rule_pipeline: RTL and testbench

- Downstream of the memory control stage: consumes its per-pixel strobes (9-bit one-hot centre, 9-bit read enables, write address) and the 9 read-data bits returned by the 9 pixel memories.
- Each 3x3 window holds exactly one pixel from each memory. This block aligns the strobes to the memory read latency, applies the Conway rule, and issues the write to the next-generation memories.
- Also owns the per-generation run/drain sequencing and the live-cell count.

---
 rtl/life_rule_pipeline.sv | 205 ++++++++++++++++++++
 tb/tb_life_rule_pipeline.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_rule_pipeline.sv
// life_rule_pipeline
// Aligns the per-pixel strobes from the memory control stage with the read
// data of the nine pixel memories. It then evaluates the Conway rule for the
// centre of each 3x3 window and issues the next-generation write. It also
// sequences one generation (run, drain, done) and counts the live cells that
// were written.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   start              single-cycle pulse, starts one generation (IDLE only)
//   gen_enable         upstream enable, high for exactly one frame of pixels
//   in_last            current upstream pixel is the last of the frame
//   in_center          one-hot bank of the centre pixel
//   in_read_enable     per-bank valid, 0 = neighbour out of bounds
//   in_write_addr      block address of the centre pixel
//   rd_data            one bit per memory, MEM_LATENCY cycles after strobes
//   out_valid          write qualifier
//   out_write_enable   one-hot bank write enable, zero when not valid
//   out_write_addr     write address
//   out_write_data     next-generation cell value
//   live_count         saturating count of live cells written this generation
//   busy               start accepted and generation not yet finished
//   done               single-cycle pulse after the last write
module life_rule_pipeline #(
  parameter int ADDR_WIDTH       = 4,
  parameter int MEM_LATENCY      = 1,
  parameter int LIVE_COUNT_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  output logic                        gen_enable,
  input  logic                        in_last,
  input  logic [8:0]                  in_center,
  input  logic [8:0]                  in_read_enable,
  input  logic [ADDR_WIDTH-1:0]       in_write_addr,
  input  logic [8:0]                  rd_data,
  output logic                        out_valid,
  output logic [8:0]                  out_write_enable,
  output logic [ADDR_WIDTH-1:0]       out_write_addr,
  output logic                        out_write_data,
  output logic [LIVE_COUNT_WIDTH-1:0] live_count,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // The drain lasts as long as the pipeline, so the last pixel's write has
  // just issued when the counter runs out.
  localparam logic [2:0] DRAIN_LOAD = 3'(MEM_LATENCY + 2);

  state_t     state;
  logic [2:0] drain_count;

  logic [8:0] center_onehot;

  logic [MEM_LATENCY-1:0]                 d_valid;
  logic [MEM_LATENCY-1:0][8:0]            d_center;
  logic [MEM_LATENCY-1:0][8:0]            d_read_enable;
  logic [MEM_LATENCY-1:0][ADDR_WIDTH-1:0] d_addr;

  logic [8:0] masked;
  logic [8:0] neighbours;
  logic       centre_live;
  logic [3:0] neighbour_count;

  logic                  s1_valid;
  logic                  s1_centre;
  logic [3:0]            s1_n;
  logic [8:0]            s1_center;
  logic [ADDR_WIDTH-1:0] s1_addr;

  logic next_cell;

  // Generation sequencing. gen_enable, busy and done are registered outputs
  // of the FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      gen_enable  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      drain_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            gen_enable <= 1'b1;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          if (in_last) begin
            state       <= DRAIN;
            gen_enable  <= 1'b0;
            drain_count <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          drain_count <= drain_count - 3'd1;
          if (drain_count == 3'd1) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Keep only the lowest set bit so a corrupted multi-hot centre can never
  // produce a multi-bank write.
  assign center_onehot = in_center & (~in_center + 9'd1);

  // S0: delay line that lines the strobes up with the memory read data.
  // A pixel is valid exactly when the upstream is enabled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_valid       <= '0;
      d_center      <= '0;
      d_read_enable <= '0;
      d_addr        <= '0;
    end else begin
      d_valid[0]       <= gen_enable;
      d_center[0]      <= center_onehot;
      d_read_enable[0] <= in_read_enable;
      d_addr[0]        <= in_write_addr;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        d_valid[i]       <= d_valid[i-1];
        d_center[i]      <= d_center[i-1];
        d_read_enable[i] <= d_read_enable[i-1];
        d_addr[i]        <= d_addr[i-1];
      end
    end
  end

  // Out-of-bounds banks are masked to dead. This includes the centre bank
  // if its read enable is low.
  always_comb begin
    masked          = rd_data & d_read_enable[MEM_LATENCY-1];
    neighbours      = masked & ~d_center[MEM_LATENCY-1];
    centre_live     = |(masked & d_center[MEM_LATENCY-1]);
    neighbour_count = '0;
    for (int i = 0; i < 9; i++) begin
      neighbour_count = neighbour_count + {3'b000, neighbours[i]};
    end
  end

  // S1 registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid  <= 1'b0;
      s1_centre <= 1'b0;
      s1_n      <= '0;
      s1_center <= '0;
      s1_addr   <= '0;
    end else begin
      s1_valid  <= d_valid[MEM_LATENCY-1];
      s1_centre <= centre_live;
      s1_n      <= neighbour_count;
      s1_center <= d_center[MEM_LATENCY-1];
      s1_addr   <= d_addr[MEM_LATENCY-1];
    end
  end

  assign next_cell = (s1_n == 4'd3) | (s1_centre & (s1_n == 4'd2));

  // S2: the write itself. The write enable is gated by valid so that idle
  // cycles never strobe a bank.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid        <= 1'b0;
      out_write_enable <= '0;
      out_write_addr   <= '0;
      out_write_data   <= 1'b0;
    end else begin
      out_valid        <= s1_valid;
      out_write_enable <= s1_center & {9{s1_valid}};
      out_write_addr   <= s1_addr;
      out_write_data   <= next_cell;
    end
  end

  // The live count is cleared when a generation is accepted. It holds its
  // value through IDLE so it can be read after done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live_count <= '0;
    end else if (state == IDLE && start) begin
      live_count <= '0;
    end else if (out_valid && out_write_data && live_count != '1) begin
      live_count <= live_count + LIVE_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_life_rule_pipeline.sv
// tb_life_rule_pipeline
// Self-checking bench for life_rule_pipeline. The main instance uses the
// default parameters. A second instance uses MEM_LATENCY=3 and
// LIVE_COUNT_WIDTH=2 to cover the latency and saturation cases. A small
// memory model delays the window bits to form rd_data. A scoreboard checks
// every write of the main instance against expectations computed from a
// Conway reference on a 6x6 grid or from hand-computed vectors.
module tb_life_rule_pipeline;

  localparam int MAIN_LAT = 1;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       in_last;
  logic [8:0] in_center;
  logic [8:0] in_read_enable;
  logic [3:0] in_write_addr;
  logic [8:0] win_bits;
  logic [2:0][8:0] rd_pipe;

  logic       gen_enable, out_valid, out_write_data, busy, done;
  logic [8:0] out_write_enable;
  logic [3:0] out_write_addr;
  logic [5:0] live_count;

  logic       gen_enable_b, out_valid_b, out_write_data_b, busy_b, done_b;
  logic [8:0] out_write_enable_b;
  logic [3:0] out_write_addr_b;
  logic [1:0] live_count_b;

  typedef struct {
    logic [8:0] center;
    logic [8:0] read_enable;
    logic [8:0] rd;
    logic [3:0] addr;
    logic [8:0] exp_en;
    logic       exp_data;
  } vec_t;

  typedef struct {
    logic [8:0] en;
    logic [3:0] addr;
    logic       data;
    int         cyc;
  } exp_t;

  vec_t vecs [9];
  exp_t exp_q [$];
  logic grid [6][6];

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_write_cyc = 0;

  life_rule_pipeline #(.ADDR_WIDTH(4), .MEM_LATENCY(MAIN_LAT), .LIVE_COUNT_WIDTH(6)) dut (
    .clk(clk), .resetn(resetn), .start(start), .gen_enable(gen_enable),
    .in_last(in_last), .in_center(in_center), .in_read_enable(in_read_enable),
    .in_write_addr(in_write_addr), .rd_data(rd_pipe[0]),
    .out_valid(out_valid), .out_write_enable(out_write_enable),
    .out_write_addr(out_write_addr), .out_write_data(out_write_data),
    .live_count(live_count), .busy(busy), .done(done)
  );

  life_rule_pipeline #(.ADDR_WIDTH(4), .MEM_LATENCY(3), .LIVE_COUNT_WIDTH(2)) dut_b (
    .clk(clk), .resetn(resetn), .start(start), .gen_enable(gen_enable_b),
    .in_last(in_last), .in_center(in_center), .in_read_enable(in_read_enable),
    .in_write_addr(in_write_addr), .rd_data(rd_pipe[2]),
    .out_valid(out_valid_b), .out_write_enable(out_write_enable_b),
    .out_write_addr(out_write_addr_b), .out_write_data(out_write_data_b),
    .live_count(live_count_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: window bits presented with the strobes come back one or
  // three cycles later.
  always @(posedge clk) rd_pipe <= {rd_pipe[1:0], win_bits};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard for the main instance: each write is checked in order
  // against the queued expectation, including its arrival cycle.
  exp_t mon_e;
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", out_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_enable", out_write_enable, mon_e.en);
        checkOutput("wr_addr", out_write_addr, mon_e.addr);
        checkOutput("wr_data", out_write_data, mon_e.data);
        checkOutput("wr_cycle", cyc, mon_e.cyc);
        last_write_cyc = cyc;
      end
    end else if (out_write_enable != 0) begin
      checkOutput("idle_wr_enable", out_write_enable, 0);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic applyStimulus(input logic [8:0] c, input logic [8:0] re, input logic [8:0] rd,
                               input logic [3:0] a, input logic last,
                               input logic [8:0] e_en, input logic e_data);
    exp_t e;
    in_center      = c;
    in_read_enable = re;
    win_bits       = rd;
    in_write_addr  = a;
    in_last        = last;
    e.en   = e_en;
    e.addr = a;
    e.data = e_data;
    e.cyc  = cyc + MAIN_LAT + 2;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic startGen();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Garbage on every input once the frame is over; it must not create writes.
  task automatic endFrame();
    in_center      = 9'h1FF;
    in_read_enable = 9'h1FF;
    win_bits       = 9'h1FF;
    in_write_addr  = 4'hF;
    in_last        = 1'b1;
  endtask

  task automatic waitDone(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("done_pulses", done_cnt, prev + 1);
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  // Builds the strobes and window bits for pixel (y,x) of the grid and the
  // Conway reference result. Banks tile the plane in 3x3, so every window
  // holds each bank exactly once.
  task automatic pixelInputs(input int y, input int x, input logic fill,
                             output logic [8:0] c, output logic [8:0] re, output logic [8:0] rd,
                             output logic [3:0] a, output logic nxt);
    int n, b, yy, xx;
    c = '0; re = '0; rd = '0; n = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        yy = y + dy;
        xx = x + dx;
        b = ((yy + 3) % 3) * 3 + ((xx + 3) % 3);
        if (yy >= 0 && yy < 6 && xx >= 0 && xx < 6) begin
          re[b] = 1'b1;
          rd[b] = grid[yy][xx];
          if (dy != 0 || dx != 0) n += int'(grid[yy][xx]);
        end else begin
          rd[b] = fill;
        end
      end
    end
    c[(y % 3) * 3 + (x % 3)] = 1'b1;
    a = 4'((y / 3) * 2 + x / 3);
    nxt = (n == 3) || (grid[y][x] && n == 2);
  endtask

  task automatic runFrame(input logic fill, input int exp_live, input string tag);
    logic [8:0] c, re, rd;
    logic [3:0] a;
    logic nxt;
    int prev;
    prev = done_cnt;
    startGen();
    for (int k = 0; k < 36; k++) begin
      pixelInputs(k / 6, k % 6, fill, c, re, rd, a, nxt);
      applyStimulus(c, re, rd, a, k == 35, c, nxt);
    end
    endFrame();
    waitDone(prev);
    checkOutput({tag, "_writes_left"}, exp_q.size(), 0);
    checkOutput({tag, "_live"}, live_count, exp_live);
    checkOutput({tag, "_done_after_last"}, done_cyc, last_write_cyc + 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int prev;

    vecs[0] = '{9'h001, 9'h01B, 9'h1EF, 4'd0,  9'h001, 1'b1};
    vecs[1] = '{9'h010, 9'h1FF, 9'h007, 4'd5,  9'h010, 1'b1};
    vecs[2] = '{9'h010, 9'h1FF, 9'h003, 4'd6,  9'h010, 1'b0};
    vecs[3] = '{9'h010, 9'h1FF, 9'h01F, 4'd7,  9'h010, 1'b0};
    vecs[4] = '{9'h010, 9'h1FF, 9'h011, 4'd8,  9'h010, 1'b0};
    vecs[5] = '{9'h010, 9'h1EF, 9'h013, 4'd3,  9'h010, 1'b0};
    vecs[6] = '{9'h010, 9'h1FF, 9'h1FF, 4'd15, 9'h010, 1'b0};
    vecs[7] = '{9'h0A0, 9'h1FF, 9'h023, 4'd10, 9'h020, 1'b1};
    vecs[8] = '{9'h100, 9'h1FF, 9'h107, 4'd12, 9'h100, 1'b1};

    resetn = 1'b1;
    start  = 1'b0;
    endFrame();
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 6; x++)
        grid[y][x] = 1'b0;

    // Reset state
    #2 resetn = 1'b0;
    #1;
    checkOutput("rst_gen_enable", gen_enable, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_wr_enable", out_write_enable, 0);
    checkOutput("rst_wr_addr", out_write_addr, 0);
    checkOutput("rst_wr_data", out_write_data, 0);
    checkOutput("rst_live", live_count, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    // Single-pixel generations from the vector table
    for (int i = 0; i < 9; i++) begin
      prev = done_cnt;
      startGen();
      checkOutput("vec_busy", busy, 1);
      applyStimulus(vecs[i].center, vecs[i].read_enable, vecs[i].rd, vecs[i].addr,
                    1'b1, vecs[i].exp_en, vecs[i].exp_data);
      endFrame();
      waitDone(prev);
      checkOutput("vec_writes_left", exp_q.size(), 0);
      checkOutput("vec_live", live_count, vecs[i].exp_data);
      checkOutput("vec_busy_after", busy, 0);
    end

    // All-dead 6x6 frame with zero read data everywhere
    runFrame(1'b0, 0, "zero");

    // Vertical blinker at (x,y) = (2,1)(2,2)(2,3); out-of-bounds reads return 1
    grid[1][2] = 1'b1;
    grid[2][2] = 1'b1;
    grid[3][2] = 1'b1;
    runFrame(1'b1, 3, "blinker");

    // MEM_LATENCY=3 instance: write appears exactly five cycles after the strobe
    prev = done_cnt;
    startGen();
    applyStimulus(9'h010, 9'h1FF, 9'h007, 4'd9, 1'b1, 9'h010, 1'b1);
    endFrame();
    for (int i = 1; i <= 6; i++) begin
      checkOutput("ml3_valid", out_valid_b, 32'(i == 5));
      if (i == 5) begin
        checkOutput("ml3_wr_enable", out_write_enable_b, 9'h010);
        checkOutput("ml3_wr_addr", out_write_addr_b, 9);
        checkOutput("ml3_wr_data", out_write_data_b, 1);
      end
      if (i == 6) checkOutput("ml3_done", done_b, 1);
      @(posedge clk); #1;
    end
    waitDone(prev);
    checkOutput("ml3_live", live_count_b, 1);

    // Five live results: saturates the 2-bit counter; start during DRAIN ignored
    prev = done_cnt;
    startGen();
    for (int k = 0; k < 6; k++)
      applyStimulus(9'h010, 9'h1FF, (k == 2) ? 9'h003 : 9'h007, 4'(k), k == 5, 9'h010, k != 2);
    endFrame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("drain_start_gen_enable", gen_enable, 0);
    checkOutput("drain_start_busy", busy, 1);
    checkOutput("drain_start_busy_b", busy_b, 1);
    waitDone(prev);
    checkOutput("sat_live_main", live_count, 5);
    checkOutput("sat_live_b", live_count_b, 3);
    repeat (6) begin
      @(posedge clk); #1;
    end
    checkOutput("drain_start_idle_busy", busy, 0);
    checkOutput("drain_start_idle_gen", gen_enable, 0);
    checkOutput("drain_start_idle_busy_b", busy_b, 0);
    checkOutput("drain_start_idle_gen_b", gen_enable_b, 0);
    checkOutput("sat_writes_left", exp_q.size(), 0);
    checkOutput("sat_live_hold", live_count, 5);

    // Reset mid-RUN with five pixels in flight
    startGen();
    for (int k = 0; k < 5; k++)
      applyStimulus(9'h010, 9'h1FF, 9'h007, 4'(k), 1'b0, 9'h010, 1'b1);
    resetn = 1'b0;
    #1;
    checkOutput("midrst_gen_enable", gen_enable, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_wr_enable", out_write_enable, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_live", live_count, 0);
    checkOutput("midrst_done", done, 0);
    exp_q.delete();
    endFrame();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    checkOutput("midrst_after_busy", busy, 0);
    checkOutput("midrst_after_gen", gen_enable, 0);
    checkOutput("midrst_after_busy_b", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
